// File: rtl/types_pkg.sv
// Shared types for the load/store path.
// Holds the store queue entry and the memory commit bundle.
package types_pkg;

  localparam int SQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ps2_data;
    logic        sw_sh_signal;
    logic [4:0]  rob_tag;
  } lsq;

  typedef struct packed {
    logic        valid;
    logic        addr_rdy;
    logic        committed;
    logic [4:0]  rob_tag;
    logic        sw_sh;
    logic [31:0] addr;
    logic [31:0] data;
  } sq_entry_t;

endpackage

// File: rtl/sq_tag_cam.sv
// Tag match of one ROB index against every store queue slot.
// Produces a one-hot hit vector when tags are unique.
module sq_tag_cam
  import types_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH
) (
  input  logic                  en,
  input  logic [4:0]            tag,
  input  logic [DEPTH-1:0]      valid,
  input  logic [DEPTH-1:0][4:0] tags,
  output logic [DEPTH-1:0]      hit
);

  // compare the tag against each live slot
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = en & valid[i] & (tags[i] == tag);
    end
  end

endmodule

// File: rtl/store_queue.sv
// In-order store queue: allocate, resolve, commit, drain.
// Flush keeps only the committed run at the head.
module store_queue
  import types_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rob_tag,
  input  logic             alloc_sw_sh,
  output logic             alloc_ready,
  input  logic             exe_valid,
  input  logic [4:0]       exe_rob_tag,
  input  logic [31:0]      exe_addr,
  input  logic [31:0]      exe_data,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rob_tag,
  input  logic             flush,
  output logic             store_wb,
  output lsq               lsq_out,
  output logic             load_mem,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  sq_entry_t             q [DEPTH];
  sq_entry_t             hd;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [DEPTH-1:0]      vld;
  logic [DEPTH-1:0]      rdy;
  logic [DEPTH-1:0]      cmt;
  logic [DEPTH-1:0][4:0] tags;
  logic [DEPTH-1:0]      exe_hit;
  logic [DEPTH-1:0]      cmt_hit;
  logic [PTR_W:0]        n_cmt;
  logic                  drain;
  logic                  do_alloc;

  // flatten entry flags for the CAMs and status
  always_comb begin
    vld  = '0;
    rdy  = '0;
    cmt  = '0;
    tags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]  = q[i].valid;
      rdy[i]  = q[i].addr_rdy;
      cmt[i]  = q[i].committed;
      tags[i] = q[i].rob_tag;
    end
  end

  sq_tag_cam #(.DEPTH(DEPTH)) u_exe_cam (
    .en    (exe_valid),
    .tag   (exe_rob_tag),
    .valid (vld),
    .tags  (tags),
    .hit   (exe_hit)
  );

  sq_tag_cam #(.DEPTH(DEPTH)) u_cmt_cam (
    .en    (commit_valid),
    .tag   (commit_rob_tag),
    .valid (vld),
    .tags  (tags),
    .hit   (cmt_hit)
  );

  assign hd          = q[head];
  assign drain       = hd.valid & hd.addr_rdy & hd.committed;
  assign alloc_ready = (count != FULL);
  assign do_alloc    = alloc_valid & alloc_ready & ~flush;
  assign load_mem    = ~|(vld & ~rdy);

  // committed survivors, including a commit landing with the flush
  always_comb begin
    n_cmt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_cmt = n_cmt + (PTR_W+1)'(vld[i] & (cmt[i] | cmt_hit[i]));
    end
  end

  // per-entry update; drain and alloc override earlier writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (exe_hit[i]) begin
          q[i].addr     <= exe_addr;
          q[i].data     <= exe_data;
          q[i].addr_rdy <= 1'b1;
        end
        if (cmt_hit[i]) q[i].committed <= 1'b1;
        if (flush && !(cmt[i] | cmt_hit[i])) q[i] <= '0;
        if (drain && PTR_W'(i) == head) q[i] <= '0;
        if (do_alloc && PTR_W'(i) == tail) begin
          q[i]         <= '0;
          q[i].valid   <= 1'b1;
          q[i].rob_tag <= alloc_rob_tag;
          q[i].sw_sh   <= alloc_sw_sh;
        end
      end
    end
  end

  // head, tail and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head + PTR_W'(drain);
      if (flush) begin
        tail  <= head + n_cmt[PTR_W-1:0];
        count <= n_cmt - (PTR_W+1)'(drain);
      end else begin
        tail  <= tail + PTR_W'(do_alloc);
        count <= count + (PTR_W+1)'(do_alloc)
                       - (PTR_W+1)'(drain);
      end
    end
  end

  // registered write pulse toward data memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_wb <= 1'b0;
      lsq_out  <= '0;
    end else begin
      store_wb <= drain;
      if (drain) begin
        lsq_out.addr         <= hd.addr;
        lsq_out.ps2_data     <= hd.data;
        lsq_out.sw_sh_signal <= hd.sw_sh;
        lsq_out.rob_tag      <= hd.rob_tag;
      end else begin
        lsq_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: queue-based reference model,
// scoreboard of expected drains, directed and random traffic.
module tb_store_queue;
  import types_pkg::*;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic [4:0]  alloc_rob_tag;
  logic        alloc_sw_sh;
  logic        alloc_ready;
  logic        exe_valid;
  logic [4:0]  exe_rob_tag;
  logic [31:0] exe_addr;
  logic [31:0] exe_data;
  logic        commit_valid;
  logic [4:0]  commit_rob_tag;
  logic        flush;
  logic        store_wb;
  lsq          lsq_out;
  logic        load_mem;
  logic [3:0]  count;

  always #5 clk = ~clk;

  store_queue #(.DEPTH(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_rob_tag  (alloc_rob_tag),
    .alloc_sw_sh    (alloc_sw_sh),
    .alloc_ready    (alloc_ready),
    .exe_valid      (exe_valid),
    .exe_rob_tag    (exe_rob_tag),
    .exe_addr       (exe_addr),
    .exe_data       (exe_data),
    .commit_valid   (commit_valid),
    .commit_rob_tag (commit_rob_tag),
    .flush          (flush),
    .store_wb       (store_wb),
    .lsq_out        (lsq_out),
    .load_mem       (load_mem),
    .count          (count)
  );

  typedef struct {
    logic [4:0]  tag;
    logic        sh;
    logic [31:0] addr;
    logic [31:0] data;
    bit          res;
    bit          cmt;
  } ment_t;

  ment_t mq[$];
  ment_t tmp[$];
  lsq    expq[$];
  lsq    e;
  int    sz0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [69:0] act,
                     input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bit has_tag(input logic [4:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit all_res();
    foreach (mq[i]) if (!mq[i].res) return 1'b0;
    return 1'b1;
  endfunction

  // reference model: program-order list of stores
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      expq.delete();
    end else begin
      sz0 = mq.size();
      if (sz0 > 0 && mq[0].res && mq[0].cmt) begin
        expq.push_back('{addr: mq[0].addr, ps2_data: mq[0].data,
                         sw_sh_signal: mq[0].sh,
                         rob_tag: mq[0].tag});
        void'(mq.pop_front());
      end
      if (exe_valid)
        foreach (mq[i])
          if (mq[i].tag == exe_rob_tag) begin
            mq[i].res  = 1'b1;
            mq[i].addr = exe_addr;
            mq[i].data = exe_data;
          end
      if (commit_valid)
        foreach (mq[i])
          if (mq[i].tag == commit_rob_tag) mq[i].cmt = 1'b1;
      if (flush) begin
        tmp.delete();
        foreach (mq[i]) if (mq[i].cmt) tmp.push_back(mq[i]);
        mq = tmp;
      end else if (alloc_valid && sz0 < D) begin
        mq.push_back('{tag: alloc_rob_tag, sh: alloc_sw_sh,
                       addr: 0, data: 0, res: 0, cmt: 0});
      end
    end
  end

  // monitor: status against model, drains against scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      chk("count", 70'(count), 70'(mq.size()));
      chk("alloc_ready", 70'(alloc_ready), 70'(mq.size() < D));
      chk("load_mem", 70'(load_mem), 70'(all_res()));
      chk("store_wb", 70'(store_wb), 70'(expq.size() > 0));
      if (store_wb && expq.size() > 0) begin
        e = expq.pop_front();
        chk("lsq_out", 70'(lsq_out), 70'(e));
      end
    end
  end

  task automatic clr();
    alloc_valid = 0; alloc_rob_tag = 0; alloc_sw_sh = 0;
    exe_valid = 0; exe_rob_tag = 0; exe_addr = 0; exe_data = 0;
    commit_valid = 0; commit_rob_tag = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    clr();
  endtask

  task automatic al(input logic [4:0] t, input logic sh);
    alloc_valid = 1; alloc_rob_tag = t; alloc_sw_sh = sh;
  endtask

  task automatic ex(input logic [4:0] t, input logic [31:0] a,
                    input logic [31:0] d);
    exe_valid = 1; exe_rob_tag = t; exe_addr = a; exe_data = d;
  endtask

  task automatic cm(input logic [4:0] t);
    commit_valid = 1; commit_rob_tag = t;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1;
    clr();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic rand_cycle(input bit settle);
    logic [4:0] t;
    int ex_i;
    int k;
    int un[$];
    ex_i = -1;
    k = -1;
    if (!settle && $urandom_range(1, 0) == 1) begin
      do t = 5'($urandom_range(31, 0)); while (has_tag(t));
      al(t, 1'($urandom_range(1, 0)));
    end
    for (int i = 0; i < mq.size(); i++)
      if (!mq[i].res) un.push_back(i);
    if (un.size() > 0 && (settle || $urandom_range(1, 0) == 1)) begin
      ex_i = settle ? un[0] : un[$urandom_range(un.size() - 1, 0)];
      ex(mq[ex_i].tag, $urandom, $urandom);
    end
    for (int i = 0; i < mq.size(); i++)
      if (!mq[i].cmt) begin
        k = i;
        break;
      end
    if (k >= 0 && (mq[k].res || k == ex_i) &&
        (settle || $urandom_range(1, 0) == 1))
      cm(mq[k].tag);
    if (!settle && $urandom_range(19, 0) == 0) flush = 1;
    tick();
  endtask

  initial begin
    reset = 1;
    clr();
    #12;
    @(negedge clk);
    #1;
    reset = 0;
    chk("rst_count", 70'(count), 70'(0));
    chk("rst_alloc_ready", 70'(alloc_ready), 70'(1));
    chk("rst_load_mem", 70'(load_mem), 70'(1));
    chk("rst_store_wb", 70'(store_wb), 70'(0));
    chk("rst_lsq_out", 70'(lsq_out), 70'(0));

    // single sw, exact drain latency after commit
    al(3, 0); tick();
    ex(3, 32'h100, 32'hDEADBEEF); tick();
    cm(3); tick();
    chk("sw_wb_early", 70'(store_wb), 70'(0));
    tick();
    chk("sw_wb", 70'(store_wb), 70'(1));
    chk("sw_addr", 70'(lsq_out.addr), 70'(32'h100));
    chk("sw_data", 70'(lsq_out.ps2_data), 70'(32'hDEADBEEF));
    chk("sw_sh", 70'(lsq_out.sw_sh_signal), 70'(0));
    chk("sw_tag", 70'(lsq_out.rob_tag), 70'(3));
    tick();

    // sh with exe and commit in the same cycle
    al(7, 1); tick();
    ex(7, 32'h20, 32'h1234); cm(7); tick();
    chk("sh_wb_early", 70'(store_wb), 70'(0));
    tick();
    chk("sh_wb", 70'(store_wb), 70'(1));
    chk("sh_flag", 70'(lsq_out.sw_sh_signal), 70'(1));
    chk("sh_addr", 70'(lsq_out.addr), 70'(32'h20));
    tick();

    // out-of-order resolve, in-order drain
    al(1, 0); tick();
    al(2, 0); tick();
    ex(2, 32'h208, 32'h22); tick();
    chk("ord_load_mem0", 70'(load_mem), 70'(0));
    ex(1, 32'h104, 32'h11); tick();
    chk("ord_load_mem1", 70'(load_mem), 70'(1));
    cm(1); tick();
    cm(2); tick();
    chk("ord_first", 70'(lsq_out.rob_tag), 70'(1));
    tick();
    chk("ord_second_wb", 70'(store_wb), 70'(1));
    chk("ord_second", 70'(lsq_out.rob_tag), 70'(2));
    tick();

    // fill to full, ignored ninth, drain, wrap
    do_reset();
    for (int i = 0; i < D; i++) begin
      al(5'(10 + i), 1'(i)); tick();
    end
    chk("full_ready", 70'(alloc_ready), 70'(0));
    al(18, 0); tick();
    chk("full_count", 70'(count), 70'(8));
    for (int i = 0; i < D; i++) begin
      ex(5'(10 + i), 32'h1000 + 32'(4 * i), 32'(i * 7));
      cm(5'(10 + i));
      tick();
    end
    tick(); tick();
    chk("drained", 70'(count), 70'(0));
    for (int i = 0; i < 3; i++) begin
      al(5'(20 + i), 0); tick();
    end
    chk("wrap_count", 70'(count), 70'(3));
    for (int i = 0; i < 3; i++) begin
      ex(5'(20 + i), 32'h40 + 32'(i), 32'(i)); cm(5'(20 + i)); tick();
    end
    tick(); tick();

    // flush keeps only the committed prefix
    al(4, 0); tick();
    al(5, 1); tick();
    al(6, 0); tick();
    al(8, 1); tick();
    cm(4); tick();
    cm(5); flush = 1; al(9, 0); tick();
    chk("flush_count", 70'(count), 70'(2));
    chk("flush_load_mem", 70'(load_mem), 70'(0));
    ex(6, 32'h66, 32'h66); tick();
    ex(4, 32'h44, 32'h44); tick();
    ex(5, 32'h55, 32'h55); tick();
    tick(); tick(); tick();
    chk("flush_empty", 70'(count), 70'(0));

    // random traffic, then settle everything out
    for (int n = 0; n < 600; n++) rand_cycle(1'b0);
    for (int n = 0; n < 40; n++) rand_cycle(1'b1);
    tick(); tick();
    chk("rand_empty", 70'(count), 70'(0));
    chk("rand_exp_left", 70'(expq.size()), 70'(0));

    // reset asserted while a write pulse is out
    al(9, 0); tick();
    ex(9, 32'h900, 32'h99); cm(9); tick();
    tick();
    chk("pre_rst_wb", 70'(store_wb), 70'(1));
    reset = 1;
    #1;
    chk("mid_rst_wb", 70'(store_wb), 70'(0));
    chk("mid_rst_count", 70'(count), 70'(0));
    chk("mid_rst_load_mem", 70'(load_mem), 70'(1));
    chk("mid_rst_lsq", 70'(lsq_out), 70'(0));
    tick();
    reset = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_queue.md
# store_queue

In-order store queue that produces the `store_wb`/`lsq` commit stream consumed by the data memory. It sits between dispatch, the memory FU and the ROB. Stores are allocated at dispatch, and their address and data are filled in when the memory FU resolves them. After ROB retirement they drain to data memory one per cycle, strictly in program order. The block also produces the conservative `load_mem` permission consumed by load issue.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; must be a power of two.
- `PTR_W`, `$clog2(DEPTH)`: width of the head and tail pointers.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `reset`, in, 1: asynchronous, active-high.
- `alloc_valid`, in, 1: dispatch of one store this cycle.
- `alloc_rob_tag`, in, 5: ROB index of the store.
- `alloc_sw_sh`, in, 1: 0 = sw, 1 = sh.
- `alloc_ready`, out, 1: queue not full.
- `exe_valid`, in, 1: memory FU resolved a store.
- `exe_rob_tag`, in, 5: ROB index of the resolved store.
- `exe_addr`, in, 32: effective byte address.
- `exe_data`, in, 32: ps2 operand value.
- `commit_valid`, in, 1: ROB retires a store.
- `commit_rob_tag`, in, 5: ROB index of the retiring store.
- `flush`, in, 1: mispredict recovery.
- `store_wb`, out, 1: one-cycle write pulse to data memory.
- `lsq_out`, out, `lsq`: `addr`, `ps2_data`, `sw_sh_signal`, `rob_tag`; valid only while `store_wb` = 1.
- `load_mem`, out, 1: a load may issue; no queued store has an unresolved address.
- `count`, out, PTR_W+1: number of occupied entries.

## Operation
Each entry holds these fields:
- Flags: `valid`, `addr_rdy`, `committed`.
- Payload: `rob_tag`, `sw_sh`, `addr`, `data`.

Circular buffer:
- `head` and `tail` wrap modulo DEPTH.
- `count` disambiguates full from empty.

Allocate:
- Accepted when `alloc_valid` and `alloc_ready` are both 1.
- Writes the entry at `tail` with `valid` = 1 and `addr_rdy` = `committed` = 0, then advances `tail`.
- `alloc_valid` while full is ignored; dispatch must stall on `alloc_ready`.

Execute:
- CAM `exe_rob_tag` against all valid entries.
- On a match: load `addr` and `data`, set `addr_rdy`.
- No match: ignored.

Commit:
- CAM `commit_rob_tag` against valid entries; on a match, set `committed`.
- Committed entries are always a contiguous run starting at `head`, because the ROB retires in order.

Drain:
- When the head entry is `valid`, `addr_rdy` and `committed`, register `store_wb` = 1 and `lsq_out` = its fields.
- Clear the entry and advance `head` on the same edge.
- At most one drain per cycle.

Flush:
- Invalidates every entry with `committed` = 0.
- `tail` ← `head` + (number of committed entries), modulo DEPTH.
- Committed entries keep draining normally.

`load_mem` = 1 when no valid entry has `addr_rdy` = 0. An empty queue gives 1.

## Timing
- Reset: all entries invalid, `head` = `tail` = 0, `count` = 0, `store_wb` = 0, `lsq_out` = '0, `alloc_ready` = 1, `load_mem` = 1.
- Reset mid-drain: `store_wb` drops immediately, and no partial write is emitted.
- `alloc_ready` and `load_mem` are combinational from registered state. There is no same-cycle bypass: a drain this cycle does not free a slot for an allocation in the same cycle.
- Latencies are counted from the edge on which the head becomes drainable, i.e. the last of `alloc_valid`/`exe_valid`/`commit_valid` sampled:
  - `store_wb` is registered and is high on the next cycle.
  - Minimum latency from `commit_valid` (sampled on edge N) to `store_wb` is 1 cycle: high during cycle N+1.
- Back-to-back committed entries produce consecutive `store_wb` pulses, one per cycle.
- Simultaneous events:
  - `exe_valid` and `commit_valid` on the same tag in the same cycle: both flags are set, and the entry drains on the following edge.
  - Allocate and drain in the same cycle: `count` is unchanged.
  - `flush` together with `alloc_valid`: flush wins and the allocation is dropped.
  - `flush` together with `exe_valid` on an uncommitted tag: the entry is invalidated.
  - `flush` together with `commit_valid`: the commit is applied before the flush evaluates, so that entry survives.
- Wrap-around: after DEPTH allocations `tail` returns to 0. With `count` = DEPTH, `alloc_ready` = 0.

## Structure
- `types_pkg` additions:
  - `sq_entry_t` struct (flags plus payload).
  - `SQ_DEPTH` default.
  - The existing `lsq` typedef is reused for `lsq_out`; the field names are unchanged.
- One sub-module, `sq_tag_cam`: DEPTH-way match of a 5-bit tag against valid entries, producing a one-hot hit vector. Instantiated twice, once for execute and once for commit.
- Storage, pointers and drain logic live in `store_queue`.

## Test plan
- Single sw: allocate rob 3, exe addr 0x100 data 0xDEADBEEF, commit rob 3 → one `store_wb` pulse one cycle later with addr 0x100, data 0xDEADBEEF, `sw_sh_signal` 0, rob_tag 3.
- Order: allocate rob 1 then rob 2, resolve rob 2 first, commit both → rob 1 drains before rob 2 on consecutive cycles. `load_mem` = 0 until rob 1 resolves.
- Full/wrap: allocate 8 stores → `alloc_ready` = 0 and a ninth `alloc_valid` is ignored. Drain all 8, then allocate 3 → tail wraps to 3 and `count` = 3.
- Flush: 4 stores with the first 2 committed, assert `flush` → `count` = 2, those 2 drain, and no `store_wb` occurs for the other 2.
- Same-cycle exe and commit for the head sh (rob 7, addr 0x20, data 0x1234) → `store_wb` next cycle with `sw_sh_signal` 1.
- Reset asserted while `store_wb` = 1 → `store_wb` drops without waiting for a clock edge, `count` = 0, `load_mem` = 1.
